micro_sequencer: RTL and testbench

- Replaces hand-selected switch patterns with a small writable control store. It sequences 28-bit microinstructions into the cpu `mir` input, one per clock.
- Supports free-run and single-step modes. Start, step and halt come from raw board switches.
- Sits between the board inputs and the cpu core, in the FPGA top level.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/btn_cond.sv | 46 ++++
 rtl/micro_sequencer.sv | 126 ++++++++++++
 tb/tb_micro_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared cpu definitions: microinstruction width, field slices and the
// micro-sequencer state encoding.
package cpu_pkg;

   localparam int MIR_W = 28;

   // Microinstruction field slices (hi/lo bit positions).
   localparam int SHIFT_HI = 27;
   localparam int SHIFT_LO = 26;
   localparam int ALU_HI   = 25;
   localparam int ALU_LO   = 20;
   localparam int MEM_HI   = 19;
   localparam int MEM_LO   = 18;
   localparam int B_HI     = 17;
   localparam int B_LO     = 14;
   localparam int C_HI     = 13;
   localparam int C_LO     = 4;
   localparam int SEL_HI   = 3;
   localparam int SEL_LO   = 0;

   localparam logic [MIR_W-1:0] MIR_NOP = '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2,
      DONE = 2'd3
   } seq_state_t;

endpackage

// File: rtl/btn_cond.sv
// Raw switch conditioning: 2-flop synchronizer, level debounce, and a
// registered one-cycle pulse on each accepted rising level.
module btn_cond #(
   parameter int DEB_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic pulse
);

   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic          level_q;
   logic [CW-1:0] cnt;

   // Any sample equal to the accepted level restarts the stability count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         level   <= 1'b0;
         level_q <= 1'b0;
         cnt     <= '0;
         pulse   <= 1'b0;
      end else begin
         sync1   <= raw;
         sync2   <= sync1;
         level_q <= level;
         pulse   <= level & ~level_q;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/micro_sequencer.sv
// Writable control store plus sequencer that feeds 28-bit microinstructions
// into the cpu mir input in free-run or single-step mode.
module micro_sequencer
   import cpu_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int AW         = 4,
   parameter int DEB_CYCLES = 250000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_sw,
   input  logic             step_sw,
   input  logic             halt_sw,
   input  logic             step_mode,
   input  logic [AW:0]      prog_len,
   input  logic             load_en,
   input  logic [AW-1:0]    load_addr,
   input  logic [MIR_W-1:0] load_data,
   output logic [MIR_W-1:0] mir,
   output logic [AW-1:0]    upc,
   output logic             busy,
   output logic             done,
   output seq_state_t       state
);

   logic start_p;
   logic step_p;
   logic halt_p;

   btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_start (
      .clk(clk), .rst_n(rst_n), .raw(start_sw), .pulse(start_p));
   btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_step (
      .clk(clk), .rst_n(rst_n), .raw(step_sw), .pulse(step_p));
   btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_halt (
      .clk(clk), .rst_n(rst_n), .raw(halt_sw), .pulse(halt_p));

   logic [MIR_W-1:0] store [DEPTH];
   logic [AW:0]      ptr;
   logic [AW:0]      len;
   logic [AW:0]      ptr_inc;
   logic             last;
   logic             load_ok;
   logic [MIR_W-1:0] rd_word;

   assign ptr_inc = ptr + (AW+1)'(1);
   assign last    = (ptr_inc == len);
   assign rd_word = store[ptr[AW-1:0]];

   // load_en is a bare write strobe with no ready: writes landing while
   // busy are dropped, and same-cycle reads see the pre-write word.
   assign load_ok = load_en && ((state == IDLE) || (state == DONE));

   always_ff @(posedge clk) begin
      if (load_ok) begin
         store[load_addr] <= load_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         mir   <= MIR_NOP;
         upc   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         ptr   <= '0;
         len   <= '0;
      end else begin
         mir <= MIR_NOP;
         if (halt_p) begin
            state <= IDLE;
            upc   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
         end else begin
            case (state)
               IDLE, DONE: begin
                  upc <= '0;
                  if (start_p) begin
                     len <= prog_len;
                     ptr <= '0;
                     if (prog_len == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end else begin
                        state <= step_mode ? STEP : RUN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                     end
                  end
               end
               RUN: begin
                  mir <= rd_word;
                  upc <= ptr[AW-1:0];
                  ptr <= ptr_inc;
                  if (last) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
               STEP: begin
                  if (step_p) begin
                     mir <= rd_word;
                     upc <= ptr[AW-1:0];
                     ptr <= ptr_inc;
                     if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer with a short debounce window.
module tb_micro_sequencer;
   import cpu_pkg::*;

   localparam int AW  = 4;
   localparam int DEB = 4;
   // raw edge -> pulse is 2+DEB+1 cycles, plus one registered FSM update
   localparam int LAT = 2 + DEB + 1 + 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start_sw = 1'b0;
   logic             step_sw = 1'b0;
   logic             halt_sw = 1'b0;
   logic             step_mode = 1'b0;
   logic [AW:0]      prog_len = '0;
   logic             load_en = 1'b0;
   logic [AW-1:0]    load_addr = '0;
   logic [MIR_W-1:0] load_data = '0;
   logic [MIR_W-1:0] mir;
   logic [AW-1:0]    upc;
   logic             busy;
   logic             done;
   seq_state_t       state;

   int errors = 0;
   int checks = 0;

   logic [MIR_W-1:0] prog4 [4] = '{28'h3100080, 28'h0021050, 28'h0011070, 28'h3520801};

   micro_sequencer #(.DEPTH(16), .AW(AW), .DEB_CYCLES(DEB)) dut (
      .clk(clk), .rst_n(rst_n), .start_sw(start_sw), .step_sw(step_sw),
      .halt_sw(halt_sw), .step_mode(step_mode), .prog_len(prog_len),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .mir(mir), .upc(upc), .busy(busy), .done(done), .state(state));

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [MIR_W-1:0] w16(input int i);
      return 28'h0A00000 + MIR_W'(i + 1);
   endfunction

   // ---------------- driver tasks ----------------
   task automatic load_word(input int a, input logic [MIR_W-1:0] d);
      @(negedge clk);
      load_en   = 1'b1;
      load_addr = AW'(a);
      load_data = d;
      @(negedge clk);
      load_en   = 1'b0;
   endtask

   task automatic release_all();
      start_sw = 1'b0;
      step_sw  = 1'b0;
      halt_sw  = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   task automatic wait_busy(output int n);
      n = 0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (busy) begin
            n = i;
            break;
         end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      #2;
      checks++;
      if (mir !== '0 || upc !== '0 || busy !== 1'b0 || done !== 1'b0 || state !== IDLE) begin
         errors++;
         $display("FAIL reset: mir=%h upc=%0d busy=%b done=%b state=%0d, required 0/0/0/0/IDLE",
                  mir, upc, busy, done, state);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_glitch();
      int bad;
      bad = 0;
      @(negedge clk);
      start_sw = 1'b1;
      repeat (2) @(negedge clk);
      start_sw = 1'b0;
      step_sw  = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy || done || state != IDLE || mir != '0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL glitch_or_idle_step: bad_cycles=%0d, required 0", bad);
      end
      release_all();
   endtask

   task automatic test_free_run();
      int n;
      for (int i = 0; i < 4; i++) load_word(i, prog4[i]);
      prog_len  = 5'd4;
      step_mode = 1'b0;
      start_sw  = 1'b1;
      wait_busy(n);
      checks++;
      if (n != LAT || state !== RUN || mir !== '0) begin
         errors++;
         $display("FAIL run_entry: latency=%0d state=%0d mir=%h, required %0d/RUN/0", n, state, mir, LAT);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (mir !== prog4[i] || upc !== AW'(i)) begin
            errors++;
            $display("FAIL run_word%0d: mir=%h upc=%0d, required %h/%0d", i, mir, upc, prog4[i], i);
         end
      end
      @(negedge clk);
      checks++;
      if (mir !== '0 || upc !== '0 || done !== 1'b1 || busy !== 1'b0 || state !== DONE) begin
         errors++;
         $display("FAIL run_end: mir=%h upc=%0d done=%b busy=%b state=%0d, required 0/0/1/0/DONE",
                  mir, upc, done, busy, state);
      end
      release_all();
   endtask

   task automatic test_single_step();
      int n;
      int k;
      int nz;
      step_mode = 1'b1;
      start_sw  = 1'b1;
      wait_busy(n);
      checks++;
      if (n != LAT || state !== STEP) begin
         errors++;
         $display("FAIL step_entry: latency=%0d state=%0d, required %0d/STEP", n, state, LAT);
      end
      for (int i = 0; i < 4; i++) begin
         step_sw = 1'b1;
         k = 0;
         for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (mir != '0) begin
               k = c;
               break;
            end
         end
         checks++;
         if (k != LAT || mir !== prog4[i] || upc !== AW'(i) || state !== ((i == 3) ? DONE : STEP)) begin
            errors++;
            $display("FAIL step_word%0d: cycles=%0d mir=%h upc=%0d state=%0d, required %0d/%h/%0d",
                     i, k, mir, upc, state, LAT, prog4[i], i);
         end
         step_sw = 1'b0;
         nz = 0;
         for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mir != '0) nz++;
         end
         checks++;
         if (nz != 0) begin
            errors++;
            $display("FAIL step_hold%0d: nonzero_cycles=%0d, required 0", i, nz);
         end
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL step_done: done=%b busy=%b, required 1/0", done, busy);
      end
      release_all();
      step_mode = 1'b0;
   endtask

   task automatic test_halt_mid_run();
      int cnt;
      int bad;
      int seen;
      for (int i = 0; i < 16; i++) load_word(i, w16(i));
      prog_len = 5'd16;
      start_sw = 1'b1;
      repeat (7) @(negedge clk);
      halt_sw = 1'b1;
      cnt = 0;
      bad = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (mir != '0) begin
            if (mir != w16(cnt)) bad++;
            cnt++;
         end else if (cnt > 0) begin
            break;
         end
      end
      checks++;
      if (cnt != 6 || bad != 0) begin
         errors++;
         $display("FAIL halt_words: issued=%0d wrong=%0d, required 6/0", cnt, bad);
      end
      checks++;
      if (mir !== '0 || busy !== 1'b0 || done !== 1'b0 || state !== IDLE || upc !== '0) begin
         errors++;
         $display("FAIL halt_state: mir=%h busy=%b done=%b state=%0d upc=%0d, required 0/0/0/IDLE/0",
                  mir, busy, done, state, upc);
      end
      release_all();
      // start and halt raised together produce coincident pulses
      start_sw = 1'b1;
      halt_sw  = 1'b1;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (busy || state != IDLE || mir != '0) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL start_halt_same_cycle: bad_cycles=%0d, required 0", seen);
      end
      release_all();
   endtask

   task automatic test_prog_len_zero();
      int n;
      int bad;
      prog_len = '0;
      start_sw = 1'b1;
      n = 0;
      bad = 0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (busy || mir != '0) bad++;
         if (done) begin
            n = c;
            break;
         end
      end
      checks++;
      if (n != LAT || bad != 0 || state !== DONE) begin
         errors++;
         $display("FAIL len0: cycles=%0d bad=%0d state=%0d, required %0d/0/DONE", n, bad, state, LAT);
      end
      release_all();
   endtask

   task automatic test_full_and_lockout();
      int n;
      prog_len = 5'd16;
      start_sw = 1'b1;
      wait_busy(n);
      checks++;
      if (n != LAT) begin
         errors++;
         $display("FAIL full_entry: latency=%0d, required %0d", n, LAT);
      end
      load_en   = 1'b1;
      load_addr = 4'd2;
      load_data = 28'hFFFFFFF;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         load_en = 1'b0;
         checks++;
         if (mir !== w16(i) || upc !== AW'(i)) begin
            errors++;
            $display("FAIL full_word%0d: mir=%h upc=%0d, required %h/%0d", i, mir, upc, w16(i), i);
         end
      end
      @(negedge clk);
      checks++;
      if (mir !== '0 || done !== 1'b1) begin
         errors++;
         $display("FAIL full_no_wrap: mir=%h done=%b, required 0/1", mir, done);
      end
      release_all();
      prog_len = 5'd3;
      start_sw = 1'b1;
      wait_busy(n);
      repeat (3) @(negedge clk);
      checks++;
      if (mir !== w16(2) || upc !== 4'd2) begin
         errors++;
         $display("FAIL lockout_rerun: mir=%h upc=%0d, required %h/2", mir, upc, w16(2));
      end
      release_all();
   endtask

   task automatic test_reset_mid_run();
      int n;
      prog_len = 5'd16;
      start_sw = 1'b1;
      wait_busy(n);
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (mir !== '0 || upc !== '0 || busy !== 1'b0 || state !== IDLE) begin
         errors++;
         $display("FAIL async_reset: mir=%h upc=%0d busy=%b state=%0d, required 0/0/0/IDLE",
                  mir, upc, busy, state);
      end
      start_sw = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      release_all();
      prog_len = 5'd1;
      start_sw = 1'b1;
      wait_busy(n);
      @(negedge clk);
      checks++;
      if (mir !== w16(0) || done !== 1'b1) begin
         errors++;
         $display("FAIL store_kept: mir=%h done=%b, required %h/1", mir, done, w16(0));
      end
      release_all();
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_free_run();
      test_single_step();
      test_halt_mid_run();
      test_prog_len_zero();
      test_full_and_lockout();
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
